add_bcd: RTL and testbench

Registered BCD adder summing a 3-digit packed-BCD operand and a 2-digit packed-BCD operand into a 4-digit packed-BCD result. Used as a decimal arithmetic stage in datapaths that carry decimal values as packed BCD nibbles. The block validates every input digit, adds digit by digit with decimal carry, and registers the result with a one-cycle latency and an error flag.

---
 rtl/add_bcd.sv | 78 +++++++
 tb/tb_add_bcd.sv | 135 +++++++++++++
 2 files changed

// File: rtl/add_bcd.sv
// Registered packed-BCD adder: 3-digit operand plus 2-digit operand gives a 4-digit sum.
// One-cycle latency; any non-decimal input nibble zeroes the sum and raises err.
module add_bcd (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [11:0] BCD_n1,
   input  logic [7:0]  BCD_n2,
   output logic [15:0] BCD_out,
   output logic        out_valid,
   output logic        err
);

   logic [19:0] all_nib;
   logic [4:0]  nib_bad;
   logic [3:0]  a_dig   [3];
   logic [3:0]  b_dig   [3];
   logic [4:0]  raw_sum [3];
   logic [3:0]  sum_dig [3];
   logic [3:0]  carry;
   logic        bad_any;
   logic [15:0] bcd_out_next;
   logic        err_next;
   logic [15:0] bcd_out_reg;
   logic        out_valid_reg;
   logic        err_reg;

   assign all_nib = {BCD_n1, BCD_n2};

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_check
         assign nib_bad[gi] = (all_nib[gi*4+3 -: 4] > 4'd9);
      end
   endgenerate

   assign bad_any = |nib_bad;

   // Operand B has no hundreds digit, so its third digit is tied to zero.
   assign a_dig[0] = BCD_n1[3:0];
   assign a_dig[1] = BCD_n1[7:4];
   assign a_dig[2] = BCD_n1[11:8];
   assign b_dig[0] = BCD_n2[3:0];
   assign b_dig[1] = BCD_n2[7:4];
   assign b_dig[2] = 4'd0;
   assign carry[0] = 1'b0;

   generate
      for (gi = 0; gi < 3; gi++) begin : g_digit
         assign raw_sum[gi]  = {1'b0, a_dig[gi]} + {1'b0, b_dig[gi]} + {4'd0, carry[gi]};
         assign carry[gi+1]  = (raw_sum[gi] > 5'd9);
         // Subtracting 10 modulo 16 is the same as adding 6 to the low nibble.
         assign sum_dig[gi]  = carry[gi+1] ? (raw_sum[gi][3:0] + 4'd6) : raw_sum[gi][3:0];
      end
   endgenerate

   assign bcd_out_next = bad_any ? 16'h0000 : {3'b000, carry[3], sum_dig[2], sum_dig[1], sum_dig[0]};
   assign err_next     = bad_any;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_out_reg   <= 16'h0000;
         err_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= in_valid;
         if (in_valid) begin
            bcd_out_reg <= bcd_out_next;
            err_reg     <= err_next;
         end
      end
   end

   assign BCD_out   = bcd_out_reg;
   assign err       = err_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_add_bcd.sv
// Directed-vector bench for add_bcd: table of back-to-back operand pairs plus
// hand-written hold and asynchronous-reset sequences.
module tb_add_bcd;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [11:0] BCD_n1 = 12'h000;
   logic [7:0]  BCD_n2 = 8'h00;
   logic [15:0] BCD_out;
   logic        out_valid;
   logic        err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] n1;
      logic [7:0]  n2;
      logic [15:0] sum;
      logic        err;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   add_bcd dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .BCD_n1    (BCD_n1),
      .BCD_n2    (BCD_n2),
      .BCD_out   (BCD_out),
      .out_valid (out_valid),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_vec(input int i);
      $display("vec %0d n1=%h n2=%h out=%h err=%b ov=%b", i, vecs[i].n1, vecs[i].n2, BCD_out, err, out_valid);
      check($sformatf("sum[%0d]", i), BCD_out, vecs[i].sum);
      check($sformatf("err[%0d]", i), {15'd0, err}, {15'd0, vecs[i].err});
      check($sformatf("ov[%0d]", i), {15'd0, out_valid}, 16'd1);
   endtask

   initial begin
      vecs[0]  = '{12'h001, 8'h99, 16'h0100, 1'b0};
      vecs[1]  = '{12'h999, 8'h00, 16'h0999, 1'b0};
      vecs[2]  = '{12'h149, 8'h89, 16'h0238, 1'b0};
      vecs[3]  = '{12'h000, 8'h00, 16'h0000, 1'b0};
      vecs[4]  = '{12'h999, 8'h99, 16'h1098, 1'b0};
      vecs[5]  = '{12'h009, 8'h01, 16'h0010, 1'b0};
      vecs[6]  = '{12'h090, 8'h10, 16'h0100, 1'b0};
      vecs[7]  = '{12'h900, 8'h99, 16'h0999, 1'b0};
      vecs[8]  = '{12'h901, 8'h99, 16'h1000, 1'b0};
      vecs[9]  = '{12'h0A0, 8'h00, 16'h0000, 1'b1};
      vecs[10] = '{12'h005, 8'h04, 16'h0009, 1'b0};
      vecs[11] = '{12'h123, 8'h0F, 16'h0000, 1'b1};
      vecs[12] = '{12'h123, 8'h45, 16'h0168, 1'b0};
      vecs[13] = '{12'hF00, 8'h00, 16'h0000, 1'b1};

      // Reset asserted between edges must clear outputs immediately.
      #1 rst = 1'b1;
      #1;
      check("rst_out", BCD_out, 16'h0000);
      check("rst_err", {15'd0, err}, 16'd0);
      check("rst_ov", {15'd0, out_valid}, 16'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Table applied back-to-back: each negedge checks the previous pair and drives the next.
      for (int i = 0; i < NVEC; i++) begin
         if (i > 0) check_vec(i - 1);
         BCD_n1   = vecs[i].n1;
         BCD_n2   = vecs[i].n2;
         in_valid = 1'b1;
         @(negedge clk);
      end
      check_vec(NVEC - 1);

      // Hold: load 149+89, then keep in_valid low while operands change.
      BCD_n1 = 12'h149; BCD_n2 = 8'h89; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         BCD_n1 = 12'h900 + 12'(k);
         BCD_n2 = 8'h77;
         @(negedge clk);
         $display("hold %0d out=%h err=%b ov=%b", k, BCD_out, err, out_valid);
         check($sformatf("hold_out[%0d]", k), BCD_out, 16'h0238);
         check($sformatf("hold_err[%0d]", k), {15'd0, err}, 16'd0);
         check($sformatf("hold_ov[%0d]", k), {15'd0, out_valid}, 16'd0);
      end

      // Async reset mid-stream while 1098 is on the output.
      BCD_n1 = 12'h999; BCD_n2 = 8'h99; in_valid = 1'b1;
      @(negedge clk);
      check("pre_rst_out", BCD_out, 16'h1098);
      check("pre_rst_ov", {15'd0, out_valid}, 16'd1);
      BCD_n1 = 12'h555; BCD_n2 = 8'h44;
      #2 rst = 1'b1;
      #1;
      $display("async rst out=%h err=%b ov=%b", BCD_out, err, out_valid);
      check("arst_out", BCD_out, 16'h0000);
      check("arst_err", {15'd0, err}, 16'd0);
      check("arst_ov", {15'd0, out_valid}, 16'd0);
      @(negedge clk);
      check("arst_hold_out", BCD_out, 16'h0000);
      check("arst_hold_ov", {15'd0, out_valid}, 16'd0);
      rst = 1'b0;
      BCD_n1 = 12'h001; BCD_n2 = 8'h99; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      $display("post rst out=%h err=%b ov=%b", BCD_out, err, out_valid);
      check("post_rst_out", BCD_out, 16'h0100);
      check("post_rst_err", {15'd0, err}, 16'd0);
      check("post_rst_ov", {15'd0, out_valid}, 16'd1);
      @(negedge clk);
      check("post_rst_ov_drop", {15'd0, out_valid}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
